series_eval_seq: RTL
====================

SERIES_EVAL_SEQ -- requirements
Module: series_eval_seq

Interface
REQ-001 SHALL take parameter DATA_W, default 16: width of x, thr, term, ans (unsigned fixed point).
REQ-002 SHALL take parameter FRAC_W, default 8: fractional bits; FRAC_W < DATA_W.
REQ-003 SHALL take parameter N_TERMS, default 8: maximum series terms, range 2..64.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request; accepted only in IDLE.
REQ-007 SHALL have port x, input, DATA_W bits: operand, sampled on acceptance.
REQ-008 SHALL have port thr, input, DATA_W bits: early-stop threshold, sampled on acceptance.
REQ-009 SHALL have port ans, output, DATA_W bits: accumulated sum, held after done.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-012 SHALL have port ovf, output, 1 bit: sticky saturation flag for the current run.
REQ-013 SHALL have port terms_used, output, $clog2(N_TERMS+1) bits: count of terms added.

Function
REQ-014 SHALL compute exp(x) as sum of t_k, with t_0 = ONE = 2^FRAC_W and t_k = ((t_{k-1}*x)>>FRAC_W)*C[k]>>FRAC_W.
REQ-015 SHALL define C[k] = floor(2^FRAC_W / k) for k = 1..N_TERMS-1, held in constant ROM.
REQ-016 SHALL implement FSM IDLE, INIT, ACC, MUL_X, MUL_C, DONE, using one multiplier per cycle.
REQ-017 IDLE: start=1 -> INIT; x and thr latched; ovf cleared.
REQ-018 INIT: term=ONE, ans=0, k=0 -> ACC.
REQ-019 ACC: if term < thr -> DONE with no add; else ans=sat(ans+term), k=k+1, then DONE if the new k==N_TERMS, else MUL_X.
REQ-020 MUL_X: term = sat((term*x)>>FRAC_W) -> MUL_C.
REQ-021 MUL_C: term = (term*C[k])>>FRAC_W, truncating -> ACC.
REQ-022 sat() SHALL clamp to 2^DATA_W-1 and set ovf; intermediate products SHALL be 2*DATA_W bits.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE; ans, ovf and terms_used=k held until next acceptance.
REQ-024 start while busy SHALL be ignored, with no queueing.
REQ-025 thr=0 SHALL disable early stop, so exactly N_TERMS terms are added.
REQ-026 A start in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-027 rst=1 at any clock edge, including mid-run, SHALL force IDLE and ans=0, busy=0, done=0, ovf=0, terms_used=0, term=0, k=0.
REQ-028 rst SHALL take priority over start in the same cycle.

Structure
REQ-029 Shared package series_pkg SHALL hold the state enum type and default parameter constants.
REQ-030 The coefficient table SHALL be sub-module series_coef_rom (params FRAC_W, N_TERMS; input k; output C[k]), computed at elaboration time.

Verification (DATA_W=16, FRAC_W=8, N_TERMS=8)
REQ-031 Scenario, x=0, thr=1, start pulse: SHALL give ans=256, terms_used=1, ovf=0, with done in the 6th cycle after start is sampled (INIT, ACC, MUL_X, MUL_C, ACC, DONE).
REQ-032 Scenario, x=256 (1.0), thr=1: term sequence SHALL be 256, 256, 128, 42, 10, 1, 0, giving ans=693, terms_used=6, ovf=0.
REQ-033 Scenario, x=256, thr=100: SHALL give ans=640, terms_used=3 (stops on t3=42).
REQ-034 Scenario, x=2048 (8.0), thr=0: SHALL give ans=65535, ovf=1, terms_used=8; ovf SHALL read 1 from the first term saturation, on the product of t2 and x.
REQ-035 Scenario, start re-pulsed while busy with different x: SHALL be ignored, and the result SHALL match the first operand.
REQ-036 Scenario, rst asserted in MUL_C: SHALL return to IDLE the next cycle with all outputs 0; a fresh start SHALL then run correctly.

Source files
------------

// File: rtl/series_pkg.sv
// Shared types and default parameters for the exp(x) series evaluator.
package series_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACC,
        S_MUL_X,
        S_MUL_C,
        S_DONE
    } state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_FRAC_W  = 8;
    localparam int DEF_N_TERMS = 8;

endpackage

// File: rtl/series_coef_rom.sv
// Constant table C[k] = floor(2^FRAC_W / k), built at elaboration time.
module series_coef_rom
    import series_pkg::*;
#(
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int N_TERMS = DEF_N_TERMS
) (
    input  logic [$clog2(N_TERMS+1)-1:0] k,
    output logic [FRAC_W:0]              c
);

    localparam int KW = $clog2(N_TERMS + 1);
    localparam int DEPTH = 1 << KW;
    localparam int unsigned ONE = 1 << FRAC_W;

    logic [FRAC_W:0] rom [DEPTH];

    // Entries for k=0 and k>=N_TERMS are never used in a run; tie them to 0.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam int unsigned CV =
            (g == 0 || g >= N_TERMS) ? 0 : ONE / ((g == 0) ? 1 : g);
        assign rom[g] = (FRAC_W + 1)'(CV);
    end

    assign c = rom[k];

endmodule

// File: rtl/series_eval_seq.sv
// Sequential exp(x) evaluator: one shared multiplier, one term per three cycles.
module series_eval_seq
    import series_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int N_TERMS = DEF_N_TERMS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DATA_W-1:0]            x,
    input  logic [DATA_W-1:0]            thr,
    output logic [DATA_W-1:0]            ans,
    output logic                         busy,
    output logic                         done,
    output logic                         ovf,
    output logic [$clog2(N_TERMS+1)-1:0] terms_used
);

    localparam int KW = $clog2(N_TERMS + 1);
    localparam int PW = 2 * DATA_W;
    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] MAXV = '1;
    localparam logic [KW-1:0]     KMAX = KW'(N_TERMS);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [DATA_W-1:0] term_q, term_d;
    logic [DATA_W-1:0] ans_q, ans_d;
    logic [KW-1:0]     k_q, k_d;
    logic              ovf_q, ovf_d;

    logic [FRAC_W:0]   coef;
    logic [DATA_W-1:0] mul_b;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     prod_sh;
    logic [DATA_W:0]   sum;
    logic [KW-1:0]     k_inc;

    series_coef_rom #(
        .FRAC_W  (FRAC_W),
        .N_TERMS (N_TERMS)
    ) u_rom (
        .k (k_q),
        .c (coef)
    );

    // Single multiplier: x in MUL_X, C[k] otherwise.
    assign mul_b   = (state_q == S_MUL_X) ? x_q : DATA_W'(coef);
    assign prod    = PW'(term_q) * PW'(mul_b);
    assign prod_sh = prod >> FRAC_W;
    assign sum     = {1'b0, ans_q} + {1'b0, term_q};
    assign k_inc   = k_q + KW'(1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        thr_d   = thr_q;
        term_d  = term_q;
        ans_d   = ans_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    thr_d   = thr;
                    ovf_d   = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                term_d  = ONE;
                ans_d   = '0;
                k_d     = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (term_q < thr_q) begin
                    state_d = S_DONE;
                end else begin
                    if (sum[DATA_W]) begin
                        ans_d = MAXV;
                        ovf_d = 1'b1;
                    end else begin
                        ans_d = sum[DATA_W-1:0];
                    end
                    k_d     = k_inc;
                    state_d = (k_inc == KMAX) ? S_DONE : S_MUL_X;
                end
            end
            S_MUL_X: begin
                if (|prod_sh[PW-1:DATA_W]) begin
                    term_d = MAXV;
                    ovf_d  = 1'b1;
                end else begin
                    term_d = prod_sh[DATA_W-1:0];
                end
                state_d = S_MUL_C;
            end
            S_MUL_C: begin
                term_d  = prod_sh[DATA_W-1:0];
                state_d = S_ACC;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            thr_q   <= '0;
            term_q  <= '0;
            ans_q   <= '0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            thr_q   <= thr_d;
            term_q  <= term_d;
            ans_q   <= ans_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ans        = ans_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign ovf        = ovf_q;
    assign terms_used = k_q;

endmodule
